// File: rtl/johnson_phase_monitor.sv
// Checks a 4-bit Johnson counter state against the legal 8-state walk.
// Decodes the state into a one-hot phase and an index, counts revolutions and flags sequence errors.
module johnson_phase_monitor #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned REV_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       jc,
  input  logic             clr_err,
  output logic [7:0]       phase,
  output logic [2:0]       phase_idx,
  output logic             locked,
  output logic             err,
  output logic             err_sticky,
  output logic [REV_W-1:0] rev_cnt,
  output logic             rev_tick
);

  localparam int unsigned CW = 4;
  localparam int unsigned IW = 3;
  localparam int unsigned PW = 8;

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_prev;
  logic [CW-1:0]   w_prev_nxt;
  logic [CW-1:0]   r_good_cnt;
  logic [CW-1:0]   w_good_nxt;
  logic [CW-1:0]   w_good_inc;
  logic [CW-1:0]   w_succ;
  logic            w_legal;
  logic            w_match;
  logic [IW-1:0]   w_idx;
  logic [IW-1:0]   w_idx_nxt;
  logic            w_locked_nxt;
  logic            w_err_nxt;
  logic            w_sticky_nxt;
  logic [REV_W-1:0] w_rev_nxt;
  logic            w_tick_nxt;
  logic [PW-1:0]   w_phase_nxt;

  // Legal-code decoder
  always_comb begin
    w_legal = 1'b1;
    w_idx   = IW'(0);
    case (jc)
      4'b0000: w_idx = IW'(0);
      4'b0001: w_idx = IW'(1);
      4'b0011: w_idx = IW'(2);
      4'b0111: w_idx = IW'(3);
      4'b1111: w_idx = IW'(4);
      4'b1110: w_idx = IW'(5);
      4'b1100: w_idx = IW'(6);
      4'b1000: w_idx = IW'(7);
      default: w_legal = 1'b0;
    endcase
  end

  // The successor of a legal code is itself legal, so a match implies legality
  assign w_succ     = {r_prev[2:0], ~r_prev[3]};
  assign w_match    = (jc == w_succ);
  assign w_good_inc = CW'(r_good_cnt + CW'(1));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_good_nxt  = r_good_cnt;
    w_idx_nxt   = phase_idx;
    w_err_nxt   = 1'b0;
    w_tick_nxt  = 1'b0;
    w_rev_nxt   = rev_cnt;
    if (en) begin
      if (w_legal) w_idx_nxt = w_idx;
      case (r_state)
        S_SEARCH: begin
          if (w_legal) begin
            w_state_nxt = S_TRACK;
            w_prev_nxt  = jc;
            w_good_nxt  = CW'(1);
          end
        end
        S_TRACK, S_LOCKED: begin
          if (w_match) begin
            w_prev_nxt = jc;
            if (r_state == S_TRACK) begin
              w_good_nxt = w_good_inc;
              if (w_good_inc == CW'(LOCK_COUNT)) w_state_nxt = S_LOCKED;
            end else if (r_prev == 4'b1000) begin
              w_rev_nxt  = REV_W'(rev_cnt + REV_W'(1));
              w_tick_nxt = 1'b1;
            end
          end else begin
            w_err_nxt = 1'b1;
            if (w_legal) begin
              w_state_nxt = S_TRACK;
              w_prev_nxt  = jc;
              w_good_nxt  = CW'(1);
            end else begin
              w_state_nxt = S_SEARCH;
              w_good_nxt  = CW'(0);
            end
          end
        end
        default: begin
          w_state_nxt = S_SEARCH;
          w_good_nxt  = CW'(0);
        end
      endcase
    end
    // A new error wins over a simultaneous clear
    w_sticky_nxt = w_err_nxt | (err_sticky & ~clr_err);
    w_locked_nxt = (w_state_nxt == S_LOCKED);
    w_phase_nxt  = w_locked_nxt ? (PW'(1) << w_idx_nxt) : PW'(0);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_SEARCH;
      r_prev     <= CW'(0);
      r_good_cnt <= CW'(0);
      phase      <= PW'(0);
      phase_idx  <= IW'(0);
      locked     <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      rev_cnt    <= REV_W'(0);
      rev_tick   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev     <= w_prev_nxt;
      r_good_cnt <= w_good_nxt;
      phase      <= w_phase_nxt;
      phase_idx  <= w_idx_nxt;
      locked     <= w_locked_nxt;
      err        <= w_err_nxt;
      err_sticky <= w_sticky_nxt;
      rev_cnt    <= w_rev_nxt;
      rev_tick   <= w_tick_nxt;
    end
  end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Scoreboard bench for johnson_phase_monitor: the driver queues expected outputs per cycle,
// a monitor pops and compares them after each rising edge.
module tb_johnson_phase_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] jc = 4'b0000;
  logic       clr_err = 1'b0;

  logic [7:0] phase, phase2;
  logic [2:0] phase_idx, phase_idx2;
  logic       locked, err, err_sticky, rev_tick;
  logic       locked2, err2, err_sticky2, rev_tick2;
  logic [7:0] rev_cnt;
  logic [1:0] rev_cnt2;

  always #5 clk = ~clk;

  johnson_phase_monitor #(.LOCK_COUNT(4), .REV_W(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .jc(jc), .clr_err(clr_err),
    .phase(phase), .phase_idx(phase_idx), .locked(locked), .err(err),
    .err_sticky(err_sticky), .rev_cnt(rev_cnt), .rev_tick(rev_tick)
  );

  johnson_phase_monitor #(.LOCK_COUNT(4), .REV_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .jc(jc), .clr_err(clr_err),
    .phase(phase2), .phase_idx(phase_idx2), .locked(locked2), .err(err2),
    .err_sticky(err_sticky2), .rev_cnt(rev_cnt2), .rev_tick(rev_tick2)
  );

  typedef struct {
    logic [7:0] phase;
    logic [2:0] idx;
    logic       lk;
    logic       er;
    logic       st;
    logic [7:0] rev;
    logic       tk;
    logic [1:0] rev2;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Expected-state model
  int   e_idx = 0;
  bit   e_lk = 1'b0;
  bit   e_st = 1'b0;
  int   e_rev = 0;
  int   e_cnt = 0;

  function automatic logic [3:0] code(input int i);
    case (i % 8)
      0: code = 4'b0000;
      1: code = 4'b0001;
      2: code = 4'b0011;
      3: code = 4'b0111;
      4: code = 4'b1111;
      5: code = 4'b1110;
      6: code = 4'b1100;
      default: code = 4'b1000;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
  endtask

  task automatic drive(input bit rn, input bit e, input logic [3:0] j, input bit c);
    @(negedge clk);
    rst = rn; en = e; jc = j; clr_err = c;
  endtask

  task automatic push(input bit er, input bit tk);
    exp_t x;
    x.phase = e_lk ? (8'd1 << e_idx) : 8'd0;
    x.idx   = 3'(e_idx);
    x.lk    = e_lk;
    x.er    = er;
    x.st    = e_st;
    x.rev   = 8'(e_rev);
    x.tk    = tk;
    x.rev2  = 2'(e_rev);
    q.push_back(x);
  endtask

  task automatic do_reset(input bit e, input logic [3:0] j);
    drive(1'b0, e, j, 1'b0);
    e_idx = 0; e_lk = 1'b0; e_st = 1'b0; e_rev = 0; e_cnt = 0;
    push(1'b0, 1'b0);
  endtask

  // First legal sample from SEARCH
  task automatic start(input int i);
    drive(1'b1, 1'b1, code(i), 1'b0);
    e_idx = i; e_cnt = 1; e_lk = 1'b0;
    push(1'b0, 1'b0);
  endtask

  task automatic step_good();
    int  n;
    bit  tk;
    n  = (e_idx + 1) % 8;
    drive(1'b1, 1'b1, code(n), 1'b0);
    tk = e_lk && (n == 0);
    if (tk) e_rev++;
    e_idx = n;
    e_cnt++;
    if (!e_lk && e_cnt >= 4) e_lk = 1'b1;
    push(1'b0, tk);
  endtask

  task automatic idle(input bit c);
    drive(1'b1, 1'b0, code(e_idx), c);
    if (c) e_st = 1'b0;
    push(1'b0, 1'b0);
  endtask

  // Mismatched but legal sample: drop to TRACK at that code
  task automatic bad_legal(input int i, input bit c);
    drive(1'b1, 1'b1, code(i), c);
    e_idx = i; e_lk = 1'b0; e_cnt = 1; e_st = 1'b1;
    push(1'b1, 1'b0);
  endtask

  task automatic bad_illegal(input bit expect_err);
    drive(1'b1, 1'b1, 4'b0101, 1'b0);
    e_lk = 1'b0; e_cnt = 0;
    if (expect_err) e_st = 1'b1;
    push(expect_err, 1'b0);
  endtask

  // Monitor: one expected entry per driven cycle
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("phase",      int'(phase),      int'(x.phase));
        chk("phase_idx",  int'(phase_idx),  int'(x.idx));
        chk("locked",     int'(locked),     int'(x.lk));
        chk("err",        int'(err),        int'(x.er));
        chk("err_sticky", int'(err_sticky), int'(x.st));
        chk("rev_cnt",    int'(rev_cnt),    int'(x.rev));
        chk("rev_tick",   int'(rev_tick),   int'(x.tk));
        chk("rev_cnt_w2", int'(rev_cnt2),   int'(x.rev2));
        chk("locked_w2",  int'(locked2),    int'(x.lk));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for two cycles
    do_reset(1'b0, 4'b0000);
    do_reset(1'b0, 4'b0000);
    // Lock from reset: 1000, 0000, 0001, 0011
    start(7);
    repeat (3) step_good();
    // First loop, then an en gap with jc frozen, then two more loops
    repeat (8) step_good();
    repeat (10) idle(1'b0);
    repeat (16) step_good();
    // Two more loops: rev_cnt 5, the 2-bit counter wraps to 1
    repeat (16) step_good();
    // Reset while locked with rev_cnt = 5
    do_reset(1'b1, code(e_idx + 1));
    // Relock, then skip 0011 -> 1111
    start(7);
    repeat (3) step_good();
    bad_legal(4, 1'b0);
    repeat (4) step_good();
    // Repeated code with clr_err on the same edge, then back-to-back repeat
    bad_legal(e_idx, 1'b1);
    bad_legal(e_idx, 1'b0);
    idle(1'b1);
    // Relock and hit an illegal code twice
    repeat (3) step_good();
    bad_illegal(1'b1);
    bad_illegal(1'b0);
    start(0);
    idle(1'b0);
    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending entries expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/johnson_phase_monitor.md
# johnson_phase_monitor

Consumes the 4-bit state of the team's 4-bit Johnson counter, one stage downstream of it. Checks that the state walks the legal 8-state Johnson sequence and decodes it into a one-hot phase and a phase index. Counts full revolutions and flags sequence errors. Downstream logic uses it as a phase-generator front end and as a health monitor for the counter.

## Interface
- LOCK_COUNT, 4: consecutive legal samples, first one included, needed to declare lock; legal range 2..15
- REV_W, 8: width of the revolution counter
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-low: sampled on rising clk, 0 = reset
- en  in  1  sample qualifier; high = the counter advanced this cycle and jc is sampled
- jc  in  4  Johnson counter state
- clr_err  in  1  clears err_sticky
- phase  out  8  one-hot decoded phase; all zero unless locked
- phase_idx  out  3  decoded index of last legal sample
- locked  out  1  sequence locked
- err  out  1  one-cycle pulse on a sequence error
- err_sticky  out  1  latched error
- rev_cnt  out  REV_W  completed revolutions while locked
- rev_tick  out  1  one-cycle pulse per completed revolution

## Operation
- Legal codes and their indices:
  - 0000 = 0, 0001 = 1, 0011 = 2, 0111 = 3
  - 1111 = 4, 1110 = 5, 1100 = 6, 1000 = 7
  - The other 8 codes are illegal.
- Successor of a code c is {c[2:0], ~c[3]}, so 1000 is followed by 0000.
- FSM states SEARCH, TRACK, LOCKED. Internal registers: prev (4 bits), good_cnt (4 bits).
- Samples with en = 0 are ignored. All state and outputs hold, and pulse outputs are 0.
- SEARCH:
  - A legal sample moves to TRACK with prev = jc, good_cnt = 1.
  - An illegal sample stays in SEARCH with no err.
- TRACK:
  - A sample equal to succ(prev) sets prev = jc and increments good_cnt. When the incremented count equals LOCK_COUNT, move to LOCKED.
  - Any other sample is an error: err pulses and err_sticky sets. A legal jc re-enters TRACK with good_cnt = 1 and prev = jc. An illegal jc goes to SEARCH.
- LOCKED:
  - A sample equal to succ(prev) updates prev and stays in LOCKED.
  - A mismatch is an error handled as in TRACK; locked deasserts on that same edge.
- A repeated code (jc == prev with en = 1) is an error. The counter must advance on every en.
- phase_idx updates on every legal sample in any state. phase = 1 << phase_idx while locked, 0 otherwise.
- Revolutions: a transition from index 7 to index 0 taken while already in LOCKED (before the edge) increments rev_cnt and pulses rev_tick. rev_cnt wraps from all-ones to 0 silently.
- err_sticky:
  - Set by an error, cleared by clr_err = 1.
  - Error and clr_err on the same edge leaves err_sticky = 1 (set wins).
  - clr_err does not depend on en.
- Reset (rst = 0 at an edge) overrides everything:
  - State goes to SEARCH; prev = 0000; good_cnt = 0.
  - All outputs return to 0: phase, phase_idx, locked, err, err_sticky, rev_cnt, rev_tick.
  - Reset mid-revolution discards the partial count.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Latency: a sample taken at edge N (en = 1) is reflected on outputs just after edge N.
- Lock timing: locked rises at the edge of the LOCK_COUNT-th consecutive legal sample. Minimum is LOCK_COUNT en-cycles after leaving reset with a running counter.
- err and rev_tick are high for exactly one clk cycle per event, including with back-to-back en.
- en may toggle arbitrarily. Gaps between samples do not break lock.

## Test plan
- **Lock from reset:** rst low 2 cycles, then en = 1 and jc stepping 1000, 0000, 0001, 0011 (LOCK_COUNT = 4) -> locked = 1 after the 4th edge; phase = 8'b0000_0100 and phase_idx = 2; err stays 0.
- **Revolution count:** locked, drive the sequence for 3 full loops -> rev_tick pulses 3 times, each at a 1000 -> 0000 sample; rev_cnt = 3. With REV_W = 2, 5 loops -> rev_cnt = 1.
- **Skip error:** locked at 0011, then drive 1111 -> err pulses 1 cycle, err_sticky = 1, locked = 0, phase = 0, state TRACK with phase_idx = 4. Four more legal steps -> relock.
- **Illegal code:** locked, drive 0101 -> err pulse, state SEARCH, phase_idx holds its last value. Drive 0101 again -> no further err.
- **en gaps and repeats:**
  - en = 0 for 10 cycles with jc frozen -> no err, outputs hold.
  - en = 1 with jc unchanged -> err pulse.
- **Clear and reset corners:**
  - clr_err alone -> err_sticky = 0.
  - clr_err on the same edge as an error -> err_sticky stays 1.
  - rst = 0 asserted while locked with rev_cnt = 5 -> every output 0 after that edge.
